// File: rtl/temporizador_mmio.sv
// -----------------------------------------------------------------------------
// temporizador_mmio
//
// Memory-mapped timer peripheral. It answers CPU accesses in a 16-byte window
// starting at BASE and provides a prescaled 32-bit down-counter with load,
// auto-reload, a sticky expiry flag and a level interrupt.
//
// Register map (word index = endereco[3:2], endereco[1:0] ignored):
//   0 CTRL   RW  bit0 EN, bit1 AUTO, bit2 IE, other bits read 0
//   1 LOAD   RW  32-bit reload value
//   2 COUNT  RW  live count; a write also restarts the prescaler
//   3 STATUS     bit0 EXP, sticky; write 1 to clear, write 0 has no effect
//
// Parameters:
//   BASE   byte address of register 0, must be 16-byte aligned
//   PRESC  clock cycles per counter tick, 1..65535
//
// Ports:
//   clock       single clock, all state changes on the rising edge
//   reset       synchronous, active-high
//   endereco    byte address from the CPU
//   indata      write data from the CPU
//   lerMem      read strobe, one cycle per access
//   escMem      write strobe, one cycle per access
//   output_mem  registered read data, zero when no response is pending
//   acerto      registered, high in the cycle read data is valid
//   irq         registered interrupt request, EXP & IE
// -----------------------------------------------------------------------------
module temporizador_mmio #(
   parameter logic [31:0] BASE  = 32'hFFFF_0000,
   parameter int unsigned PRESC = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] endereco,
   input  logic [31:0] indata,
   input  logic        lerMem,
   input  logic        escMem,
   output logic [31:0] output_mem,
   output logic        acerto,
   output logic        irq
);

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_LOAD   = 2'd1,
      REG_COUNT  = 2'd2,
      REG_STATUS = 2'd3
   } reg_idx_t;

   // Last prescaler value before it wraps and emits a tick.
   localparam logic [15:0] PRESC_LAST = 16'(PRESC - 1);

   // ---------------------------------------------------------------------------
   // Architectural state
   // ---------------------------------------------------------------------------
   logic        en;
   logic        auto_rl;
   logic        ie;
   logic [31:0] load_q;
   logic [31:0] count_q;
   logic [15:0] presc_q;
   logic        exp_q;

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic     sel;
   reg_idx_t idx;
   logic     wr;
   logic     rd;
   logic     wr_ctrl;
   logic     wr_load;
   logic     wr_count;
   logic     wr_status;
   logic     unused_addr_bits;

   assign sel = (endereco[31:4] == BASE[31:4]);
   assign idx = reg_idx_t'(endereco[3:2]);
   assign wr  = sel & escMem;
   // A simultaneous write takes the access; the read is dropped.
   assign rd  = sel & lerMem & ~escMem;

   assign wr_ctrl   = wr & (idx == REG_CTRL);
   assign wr_load   = wr & (idx == REG_LOAD);
   assign wr_count  = wr & (idx == REG_COUNT);
   assign wr_status = wr & (idx == REG_STATUS);

   // Byte offset within a word carries no meaning for this block.
   assign unused_addr_bits = ^endereco[1:0];

   // ---------------------------------------------------------------------------
   // Tick and expiry
   // ---------------------------------------------------------------------------
   logic tick;
   logic tick_eff;
   logic expire;

   assign tick     = en & (presc_q == PRESC_LAST);
   // A COUNT write in the tick cycle owns the counter: the tick is discarded.
   assign tick_eff = tick & ~wr_count;
   // Count never goes below zero, so a tick at 1 or 0 is the expiry event.
   assign expire   = tick_eff & (count_q <= 32'd1);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   logic        en_d;
   logic        auto_d;
   logic        ie_d;
   logic [31:0] load_d;
   logic [31:0] count_d;
   logic [15:0] presc_d;
   logic        exp_d;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // that no path leaves it unassigned, which would infer a latch.
      en_d    = en;
      auto_d  = auto_rl;
      ie_d    = ie;
      load_d  = load_q;
      count_d = count_q;
      presc_d = presc_q + 16'd1;
      exp_d   = exp_q;

      // Prescaler restarts on disable, on any CTRL or COUNT write, and on wrap.
      if (!en || wr_ctrl || wr_count || tick) begin
         presc_d = 16'd0;
      end

      if (wr_count) begin
         count_d = indata;
      end else if (tick_eff) begin
         if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
         end else if (auto_rl) begin
            count_d = load_q;
         end else begin
            count_d = 32'd0;
         end
      end

      // A CTRL write in the same cycle as a one-shot expiry keeps the written EN.
      if (wr_ctrl) begin
         en_d   = indata[0];
         auto_d = indata[1];
         ie_d   = indata[2];
      end else if (expire && !auto_rl) begin
         en_d = 1'b0;
      end

      if (wr_load) begin
         load_d = indata;
      end

      // Set beats clear when both happen in the same cycle.
      if (expire) begin
         exp_d = 1'b1;
      end else if (wr_status && indata[0]) begin
         exp_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Read mux: values are the pre-edge register contents of the strobe cycle.
   // ---------------------------------------------------------------------------
   logic [31:0] rd_data;

   always_comb begin
      rd_data = 32'd0;
      unique case (idx)
         REG_CTRL:   rd_data = {29'd0, ie, auto_rl, en};
         REG_LOAD:   rd_data = load_q;
         REG_COUNT:  rd_data = count_q;
         REG_STATUS: rd_data = {31'd0, exp_q};
         default:    rd_data = 32'd0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         en         <= 1'b0;
         auto_rl    <= 1'b0;
         ie         <= 1'b0;
         load_q     <= 32'd0;
         count_q    <= 32'd0;
         presc_q    <= 16'd0;
         exp_q      <= 1'b0;
         output_mem <= 32'd0;
         acerto     <= 1'b0;
         irq        <= 1'b0;
      end else begin
         en         <= en_d;
         auto_rl    <= auto_d;
         ie         <= ie_d;
         load_q     <= load_d;
         count_q    <= count_d;
         presc_q    <= presc_d;
         exp_q      <= exp_d;
         output_mem <= rd ? rd_data : 32'd0;
         acerto     <= rd;
         // irq follows EXP & IE one cycle later.
         irq        <= exp_q & ie;
      end
   end

endmodule

// File: tb/tb_temporizador_mmio.sv
// -----------------------------------------------------------------------------
// tb_temporizador_mmio
//
// Self-checking bench for temporizador_mmio. Reads push their expected data to
// a queue tagged with the cycle the response is due; a monitor on the falling
// edge compares acerto/output_mem every cycle against the queue head.
// All tasks are entered on a falling edge and return on a falling edge.
// -----------------------------------------------------------------------------
module tb_temporizador_mmio;

   localparam logic [31:0] BASE     = 32'hFFFF_0000;
   localparam logic [31:0] A_CTRL   = BASE + 32'h0;
   localparam logic [31:0] A_LOAD   = BASE + 32'h4;
   localparam logic [31:0] A_COUNT  = BASE + 32'h8;
   localparam logic [31:0] A_STATUS = BASE + 32'hC;

   logic        clock;
   logic        reset;
   logic [31:0] endereco;
   logic [31:0] indata;
   logic        lerMem;
   logic        escMem;
   logic [31:0] output_mem;
   logic        acerto;
   logic        irq;

   temporizador_mmio #(
      .BASE  (BASE),
      .PRESC (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .endereco   (endereco),
      .indata     (indata),
      .lerMem     (lerMem),
      .escMem     (escMem),
      .output_mem (output_mem),
      .acerto     (acerto),
      .irq        (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Rising-edge counter; after edge k, cyc == k.
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_vectors     = 0;
   int n_miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      string       tag;
      logic [31:0] exp;
      int          due;
   } rd_t;

   rd_t rd_q[$];
   bit  mon_on = 1'b0;

   // Response monitor: acerto must be high exactly when a read is due.
   always @(negedge clock) begin
      if (mon_on) begin
         if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            check({rd_q[0].tag, "_acerto"}, acerto, 1'b1);
            check(rd_q[0].tag, output_mem, rd_q[0].exp);
            void'(rd_q.pop_front());
         end else begin
            check("idle_acerto", acerto, 1'b0);
            check("idle_rdata", output_mem, 32'd0);
         end
      end
   end

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      endereco = addr;
      indata   = data;
      escMem   = 1'b1;
      @(negedge clock);
      escMem   = 1'b0;
      endereco = 32'd0;
      indata   = 32'd0;
   endtask

   task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      rd_t item;
      item.tag = tag;
      item.exp = exp;
      item.due = cyc + 1;
      rd_q.push_back(item);
      endereco = addr;
      lerMem   = 1'b1;
      @(negedge clock);
      lerMem   = 1'b0;
      endereco = 32'd0;
   endtask

   // Strobe with no expected response (unselected read or read+write).
   task automatic bus_raw(input logic [31:0] addr, input logic [31:0] data,
                          input logic rd, input logic wr);
      endereco = addr;
      indata   = data;
      lerMem   = rd;
      escMem   = wr;
      @(negedge clock);
      lerMem   = 1'b0;
      escMem   = 1'b0;
      endereco = 32'd0;
      indata   = 32'd0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clock);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      reset    = 1'b1;
      endereco = 32'd0;
      indata   = 32'd0;
      lerMem   = 1'b0;
      escMem   = 1'b0;
      repeat (3) @(negedge clock);
      reset  = 1'b0;
      mon_on = 1'b1;

      // ---- Reset state ----
      check("rst_irq", irq, 1'b0);
      bus_read(A_CTRL,   32'd0, "rst_ctrl");
      bus_read(A_LOAD,   32'd0, "rst_load");
      bus_read(A_COUNT,  32'd0, "rst_count");
      bus_read(A_STATUS, 32'd0, "rst_status");

      // ---- One-shot: COUNT=3, CTRL=EN|IE at edge e ----
      bus_write(A_COUNT, 32'd3);
      bus_write(A_CTRL, 32'h5);
      e = cyc;
      wait_until(e + 3);
      bus_read(A_COUNT, 32'd3, "os_count_e3");
      bus_read(A_COUNT, 32'd2, "os_count_e4");
      wait_until(e + 8);
      bus_read(A_COUNT, 32'd1, "os_count_e8");
      wait_until(e + 12);
      check("os_irq_e12", irq, 1'b0);
      bus_read(A_STATUS, 32'd1, "os_status_e12");
      check("os_irq_e13", irq, 1'b1);
      bus_read(A_CTRL,  32'h4, "os_ctrl_after");
      bus_read(A_COUNT, 32'd0, "os_count_after");
      bus_write(A_STATUS, 32'd1);
      check("os_irq_clear_edge", irq, 1'b1);
      @(negedge clock);
      check("os_irq_cleared", irq, 1'b0);
      bus_read(A_STATUS, 32'd0, "os_status_cleared");

      // ---- Auto-reload: LOAD=2, COUNT=2, CTRL=EN|AUTO at edge e ----
      bus_write(A_LOAD, 32'd2);
      bus_write(A_COUNT, 32'd2);
      bus_write(A_CTRL, 32'h3);
      e = cyc;
      wait_until(e + 2);
      bus_read(A_COUNT, 32'd2, "ar_count_e2");
      wait_until(e + 4);
      bus_read(A_COUNT, 32'd1, "ar_count_e4");
      wait_until(e + 8);
      bus_read(A_COUNT, 32'd2, "ar_count_e8");
      bus_read(A_STATUS, 32'd1, "ar_status_e9");
      wait_until(e + 12);
      bus_read(A_COUNT, 32'd1, "ar_count_e12");
      bus_write(A_STATUS, 32'd0);
      bus_read(A_STATUS, 32'd1, "ar_status_w0");
      check("ar_irq_ie_off", irq, 1'b0);

      // STATUS clear sampled at the expiry edge e+16: set wins.
      wait_until(e + 15);
      bus_write(A_STATUS, 32'd1);
      bus_read(A_STATUS, 32'd1, "col_status_set_wins");
      bus_read(A_COUNT, 32'd2, "col_count_reloaded");

      // COUNT write sampled at tick edge e+20: write wins, prescaler restarts.
      wait_until(e + 19);
      bus_write(A_COUNT, 32'h10);
      bus_read(A_COUNT, 32'h10, "col_count_written");
      wait_until(e + 23);
      bus_read(A_COUNT, 32'h10, "col_count_e23");
      bus_read(A_COUNT, 32'h0F, "col_count_e24");
      bus_write(A_STATUS, 32'd1);
      bus_read(A_STATUS, 32'd0, "ar_status_cleared");

      // ---- Address decode ----
      bus_write(A_CTRL, 32'd0);
      bus_write(A_LOAD, 32'h0000_1234);
      bus_write(BASE + 32'h14, 32'hDEAD_BEEF);
      bus_write(BASE - 32'h4,  32'hDEAD_BEEF);
      bus_write(BASE - 32'hC,  32'hDEAD_BEEF);
      bus_raw(BASE + 32'h14, 32'd0, 1'b1, 1'b0);
      bus_raw(BASE - 32'h4,  32'd0, 1'b1, 1'b0);
      bus_read(A_LOAD, 32'h0000_1234, "dec_load_untouched");
      bus_read(A_STATUS, 32'd0, "dec_status_untouched");
      bus_write(BASE + 32'h5, 32'h0000_A5A5);
      bus_read(A_LOAD, 32'h0000_A5A5, "dec_misaligned_wr");
      bus_read(BASE + 32'h6, 32'h0000_A5A5, "dec_misaligned_rd");
      bus_raw(A_LOAD, 32'h0000_0077, 1'b1, 1'b1);
      bus_read(A_LOAD, 32'h0000_0077, "dec_rw_collision");

      // ---- Reset mid-operation with EXP=1, irq=1 ----
      bus_write(A_LOAD, 32'd3);
      bus_write(A_COUNT, 32'd1);
      bus_write(A_CTRL, 32'h7);
      e = cyc;
      wait_until(e + 6);
      check("mr_irq_before", irq, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("mr_irq_after", irq, 1'b0);
      bus_read(A_CTRL,   32'd0, "mr_ctrl");
      bus_read(A_LOAD,   32'd0, "mr_load");
      bus_read(A_COUNT,  32'd0, "mr_count");
      bus_read(A_STATUS, 32'd0, "mr_status");
      repeat (5) @(negedge clock);
      bus_read(A_STATUS, 32'd0, "mr_status_later");
      check("mr_irq_later", irq, 1'b0);

      // Fresh start after reset: first decrement exactly PRESC edges later.
      bus_write(A_COUNT, 32'd5);
      bus_write(A_CTRL, 32'h1);
      e = cyc;
      wait_until(e + 3);
      bus_read(A_COUNT, 32'd5, "fs_count_e3");
      bus_read(A_COUNT, 32'd4, "fs_count_e4");

      repeat (3) @(negedge clock);
      check("rd_queue_empty", rd_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
